// File: rtl/dsp_add_v3_sched_pkg.sv
// Shared types and constants for the round-robin scheduler in front of the
// three-lane SIMD DSP adder.
package dsp_add_v3_sched_pkg;

  localparam int LANES  = 3;
  localparam int LANE_W = 12;
  localparam int IDX_W  = 3;

  typedef struct packed {
    logic              vld;
    logic [IDX_W-1:0]  idx;
    logic [LANE_W-1:0] a;
    logic [LANE_W-1:0] b;
  } lane_t;

  typedef struct packed {
    logic              vld;
    logic [IDX_W-1:0]  idx;
    logic [LANE_W-1:0] y;
  } res_t;

  function automatic logic [1:0] count_lanes(input logic [LANES-1:0] v);
    logic [1:0] c;
    c = '0;
    for (int k = 0; k < LANES; k++) c = c + 2'(v[k]);
    return c;
  endfunction

endpackage

// File: rtl/dsp_add_v3_sched_if.sv
// Request/response bundle between the scalar-add clients (master) and the
// shared-DSP scheduler (slave).
interface dsp_add_v3_sched_if #(
  parameter int width = 12,
  parameter int n     = 4
);

  logic [n-1:0]       req_valid;
  logic [n-1:0]       req_ready;
  logic [n*width-1:0] req_a;
  logic [n*width-1:0] req_b;
  logic [n-1:0]       rsp_valid;
  logic [n*width-1:0] rsp_y;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_y
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_y
  );

endinterface

// File: rtl/dsp_add_v3.sv
// Behavioural view of the SIMD DSP adder in FOUR12 mode: four independent
// 12-bit lanes, carries never cross a lane boundary.
module dsp_add_v3
  import dsp_add_v3_sched_pkg::*;
#(
  parameter bit preg = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic [LANE_W-1:0]   a0, b0, a1, b1, a2, b2, a3, b3,
  output logic [4*LANE_W-1:0] p
);

  logic [4*LANE_W-1:0] ab;
  logic [4*LANE_W-1:0] c;
  logic [4*LANE_W-1:0] sum;
  logic [4*LANE_W-1:0] p_q;

  assign ab = {a3, a2, a1, a0};
  assign c  = {b3, b2, b1, b0};

  always_comb begin
    sum = '0;
    for (int k = 0; k < 4; k++)
      sum[k*LANE_W +: LANE_W] = ab[k*LANE_W +: LANE_W] + c[k*LANE_W +: LANE_W];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   p_q <= '0;
    else if (ce) p_q <= sum;
  end

  assign p = preg ? p_q : sum;

endmodule

// File: rtl/dsp_add_v3_rr_pick.sv
// Combinational round-robin picker: grants up to three requesters starting at
// rr with wrap-around and reports which requester lands in each lane.
module dsp_add_v3_rr_pick
  import dsp_add_v3_sched_pkg::*;
#(
  parameter int n = 4
) (
  input  logic [n-1:0]                  req_valid,
  input  logic [IDX_W-1:0]              rr,
  output logic [n-1:0]                  grant,
  output logic [LANES-1:0][IDX_W-1:0]   lane_idx,
  output logic [LANES-1:0]              lane_vld,
  output logic [IDX_W-1:0]              rr_next
);

  // The k-th granted requester in scan order occupies lane k.
  always_comb begin
    int pos;
    int cnt;
    int last;
    grant    = '0;
    lane_idx = '0;
    lane_vld = '0;
    rr_next  = rr;
    cnt      = 0;
    last     = 0;
    for (int k = 0; k < n; k++) begin
      pos = int'(rr) + k;
      if (pos >= n) pos = pos - n;
      for (int i = 0; i < n; i++) begin
        if (i == pos && req_valid[i] && cnt < LANES) begin
          grant[i] = 1'b1;
          for (int l = 0; l < LANES; l++) begin
            if (l == cnt) begin
              lane_idx[l] = IDX_W'(i);
              lane_vld[l] = 1'b1;
            end
          end
          cnt  = cnt + 1;
          last = i;
        end
      end
    end
    if (cnt > 0) rr_next = (last + 1 >= n) ? '0 : IDX_W'(last + 1);
  end

endmodule

// File: rtl/dsp_add_v3_sched.sv
// Shares one three-lane DSP adder among n requesters: round-robin pick, lane
// operand register (S1), sum register (S2), then per-requester response decode.
module dsp_add_v3_sched
  import dsp_add_v3_sched_pkg::*;
#(
  parameter int width = 12,
  parameter int n     = 4
) (
  input  logic               clock,
  input  logic               reset,
  dsp_add_v3_sched_if.slave  bus,
  output logic [1:0]         lanes_busy
);

  if (width < 1 || width > LANE_W) begin : g_bad_width
    $error("dsp_add_v3_sched: width %0d outside 1..%0d", width, LANE_W);
  end
  if (n < 1 || n > 8) begin : g_bad_n
    $error("dsp_add_v3_sched: n %0d outside 1..8", n);
  end

  logic [n-1:0]                grant;
  logic [LANES-1:0][IDX_W-1:0] lane_idx;
  logic [LANES-1:0]            lane_vld;
  logic [IDX_W-1:0]            rr;
  logic [IDX_W-1:0]            rr_next;
  lane_t [LANES-1:0]           s1_d;
  lane_t [LANES-1:0]           s1;
  res_t  [LANES-1:0]           s2;
  logic [4*LANE_W-1:0]         dsp_p;
  logic [LANE_W-1:0]           lane3_unused;
  logic [n-1:0]                rsp_valid_q;
  logic [n*width-1:0]          rsp_y_q;

  dsp_add_v3_rr_pick #(.n(n)) u_pick (
    .req_valid (bus.req_valid),
    .rr        (rr),
    .grant     (grant),
    .lane_idx  (lane_idx),
    .lane_vld  (lane_vld),
    .rr_next   (rr_next)
  );

  assign bus.req_ready = grant;

  // Ungranted lanes load all-zero so idle lanes feed zeros into the DSP.
  always_comb begin
    s1_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_vld[l]) begin
        s1_d[l].vld = 1'b1;
        s1_d[l].idx = lane_idx[l];
        for (int i = 0; i < n; i++) begin
          if (lane_idx[l] == IDX_W'(i)) begin
            s1_d[l].a = LANE_W'(bus.req_a[i*width +: width]);
            s1_d[l].b = LANE_W'(bus.req_b[i*width +: width]);
          end
        end
      end
    end
  end

  dsp_add_v3 #(.preg(1'b0)) u_dsp (
    .clock (clock),
    .reset (reset),
    .ce    (1'b0),
    .a0    (s1[0].a),
    .b0    (s1[0].b),
    .a1    (s1[1].a),
    .b1    (s1[1].b),
    .a2    (s1[2].a),
    .b2    (s1[2].b),
    .a3    ('0),
    .b3    ('0),
    .p     (dsp_p)
  );

  assign lane3_unused = dsp_p[3*LANE_W +: LANE_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr         <= '0;
      s1         <= '0;
      s2         <= '0;
      lanes_busy <= '0;
    end else begin
      rr         <= rr_next;
      s1         <= s1_d;
      lanes_busy <= count_lanes(lane_vld);
      for (int l = 0; l < LANES; l++) begin
        s2[l].vld <= s1[l].vld;
        s2[l].idx <= s1[l].idx;
        s2[l].y   <= dsp_p[l*LANE_W +: LANE_W];
      end
    end
  end

  // Lane indices are distinct, so at most one lane targets any requester slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
    end else begin
      rsp_valid_q <= '0;
      for (int i = 0; i < n; i++) begin
        for (int l = 0; l < LANES; l++) begin
          if (s2[l].vld && s2[l].idx == IDX_W'(i)) begin
            rsp_valid_q[i]           <= 1'b1;
            rsp_y_q[i*width +: width] <= s2[l].y[width-1:0];
          end
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_dsp_add_v3_sched.sv
// Directed bench for dsp_add_v3_sched: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_dsp_add_v3_sched;

  logic       clock;
  logic       reset;
  logic [1:0] lanes_busy;
  logic [1:0] lanes_busy8;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  dsp_add_v3_sched_if #(.width(12), .n(4)) bus ();
  dsp_add_v3_sched_if #(.width(8),  .n(2)) bus8 ();

  dsp_add_v3_sched #(.width(12), .n(4)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .lanes_busy (lanes_busy)
  );

  dsp_add_v3_sched #(.width(8), .n(2)) u_dut8 (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus8),
    .lanes_busy (lanes_busy8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {12'(x3), 12'(x2), 12'(x1), 12'(x0)};
  endfunction

  task automatic apply_stimulus(input logic [3:0] v, input logic [47:0] a, input logic [47:0] b);
    @(posedge clock);
    #1;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset         = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Reference model: scan from rr with wrap, up to three grants, each sum due
  // three sampling points later; results per requester form a FIFO.
  int          q_due [4][$];
  logic [11:0] q_val [4][$];
  logic [11:0] exp_y [4];
  int          cyc      = 0;
  int          m_rr     = 0;
  int          prev_cnt = 0;

  always @(negedge clock) begin
    logic [3:0]  exp_v;
    logic [3:0]  exp_g;
    logic [47:0] exp_y_bus;
    int          pos;
    int          cnt;
    int          last;
    int          av;
    int          bv;
    if (reset) begin
      m_rr     = 0;
      prev_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        q_due[i].delete();
        q_val[i].delete();
        exp_y[i] = '0;
      end
    end
    exp_v = '0;
    for (int i = 0; i < 4; i++) begin
      if (q_due[i].size() > 0 && q_due[i][0] == cyc) begin
        exp_v[i] = 1'b1;
        exp_y[i] = q_val[i].pop_front();
        void'(q_due[i].pop_front());
      end
    end
    exp_y_bus = {exp_y[3], exp_y[2], exp_y[1], exp_y[0]};
    check_output("model_rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
    check_output("model_rsp_y", 64'(bus.rsp_y), 64'(exp_y_bus));
    check_output("model_lanes_busy", 64'(lanes_busy), 64'(prev_cnt));
    exp_g = '0;
    cnt   = 0;
    last  = 0;
    for (int k = 0; k < 4; k++) begin
      pos = (m_rr + k) % 4;
      if (bus.req_valid[pos[1:0]] && cnt < 3) begin
        exp_g[pos[1:0]] = 1'b1;
        cnt  = cnt + 1;
        last = pos;
        if (!reset) begin
          av = int'((bus.req_a >> (12 * pos)) & 48'hFFF);
          bv = int'((bus.req_b >> (12 * pos)) & 48'hFFF);
          q_due[pos[1:0]].push_back(cyc + 3);
          q_val[pos[1:0]].push_back(12'((av + bv) % 4096));
        end
      end
    end
    check_output("model_req_ready", 64'(bus.req_ready), 64'(exp_g));
    if (!reset) begin
      if (cnt > 0) m_rr = (last + 1) % 4;
      prev_cnt = cnt;
    end
    cyc++;
  end

  logic [3:0] rr_exp [3];
  logic [3:0] tbl_v  [6];

  initial begin
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus8.req_valid = '0;
    bus8.req_a     = '0;
    bus8.req_b     = '0;
    rr_exp[0] = 4'b0111;
    rr_exp[1] = 4'b1011;
    rr_exp[2] = 4'b1101;
    tbl_v[0] = 4'b1010;
    tbl_v[1] = 4'b0001;
    tbl_v[2] = 4'b1110;
    tbl_v[3] = 4'b1111;
    tbl_v[4] = 4'b0000;
    tbl_v[5] = 4'b0101;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_output("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_output("reset_rsp_y", 64'(bus.rsp_y), 64'd0);
    check_output("reset_lanes_busy", 64'(lanes_busy), 64'd0);
    check_output("reset_rsp_valid8", 64'(bus8.rsp_valid), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] single requester 2");
    apply_stimulus(4'b0100, pack4(0, 0, 5, 0), pack4(0, 0, 7, 0));
    @(negedge clock);
    check_output("single_ready", 64'(bus.req_ready), 64'b0100);
    apply_stimulus(4'b0000, '0, '0);
    repeat (3) @(negedge clock);
    check_output("single_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
    check_output("single_rsp_y2", 64'(bus.rsp_y[35:24]), 64'd12);

    $display("[TB] all four valid, rotation");
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(4'b1111, pack4(c*4+1, c*4+2, c*4+3, c*4+4), pack4(100, 200, 300, 400));
      @(negedge clock);
      check_output($sformatf("rotate_ready_%0d", c), 64'(bus.req_ready), 64'(rr_exp[c]));
      if (c > 0) check_output($sformatf("rotate_busy_%0d", c), 64'(lanes_busy), 64'd3);
    end
    apply_stimulus(4'b0000, '0, '0);
    repeat (4) @(negedge clock);

    $display("[TB] lane wrap-around, width 12 and width 8");
    do_reset();
    apply_stimulus(4'b0011, pack4(12'hFFF, 1, 0, 0), pack4(1, 2, 0, 0));
    bus8.req_valid = 2'b11;
    bus8.req_a     = {8'h7F, 8'h80};
    bus8.req_b     = {8'h01, 8'h80};
    apply_stimulus(4'b0000, '0, '0);
    bus8.req_valid = '0;
    repeat (3) @(negedge clock);
    check_output("wrap_rsp_valid", 64'(bus.rsp_valid), 64'b0011);
    check_output("wrap_lane0", 64'(bus.rsp_y[11:0]), 64'd0);
    check_output("wrap_lane1", 64'(bus.rsp_y[23:12]), 64'd3);
    check_output("w8_rsp_valid", 64'(bus8.rsp_valid), 64'b11);
    check_output("w8_y0", 64'(bus8.rsp_y[7:0]), 64'h00);
    check_output("w8_y1", 64'(bus8.rsp_y[15:8]), 64'h80);

    $display("[TB] reset with S1 and S2 occupied");
    apply_stimulus(4'b1111, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    apply_stimulus(4'b1111, pack4(9, 10, 11, 12), pack4(1, 1, 1, 1));
    @(negedge clock);
    check_output("pre_reset_busy", 64'(lanes_busy), 64'd3);
    @(posedge clock);
    #1;
    reset         = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      check_output($sformatf("drop_rsp_valid_%0d", j), 64'(bus.rsp_valid), 64'd0);
    end
    apply_stimulus(4'b1111, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2));
    @(negedge clock);
    check_output("restart_ready", 64'(bus.req_ready), 64'b0111);
    apply_stimulus(4'b0000, '0, '0);

    $display("[TB] back-to-back requester 1");
    apply_stimulus(4'b0010, pack4(0, 4, 0, 0),  pack4(0, 6, 0, 0));
    apply_stimulus(4'b0010, pack4(0, 15, 0, 0), pack4(0, 5, 0, 0));
    apply_stimulus(4'b0010, pack4(0, 25, 0, 0), pack4(0, 5, 0, 0));
    apply_stimulus(4'b0000, '0, '0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      check_output($sformatf("b2b_valid_%0d", j), 64'(bus.rsp_valid), 64'b0010);
      check_output($sformatf("b2b_y_%0d", j), 64'(bus.rsp_y[23:12]), 64'((j + 1) * 10));
    end

    $display("[TB] mixed pattern table");
    for (int t = 0; t < 6; t++)
      apply_stimulus(tbl_v[t], pack4(t*100+7, t*50+4095, t*3+11, 4000),
                     pack4(t*9+1, t+2, 4090, t*200+96));
    apply_stimulus(4'b0000, '0, '0);
    repeat (5) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/dsp_add_v3_sched.md
# dsp_add_v3_sched

Round-robin scheduler that shares one three-lane SIMD DSP adder (`dsp_add_v3`, FOUR12 mode, lane 3 unused) among `n` independent add requesters. Each cycle it grants up to three distinct requesters and packs their operand pairs into lanes 0..2. It registers the lane operands in front of the DSP and the sums behind it. Each result goes back to its originating requester with a fixed 2-cycle latency. It sits between scalar-add clients (counters, address generators) and the single placed DSP48E2 site.

## Interface
- `width`, 12, operand/result width; legal range 1..12 (elaboration `$error` outside).
- `n`, 4, number of requesters; legal range 1..8.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  n  requester i has an operand pair.
- `req_ready`  out  n  requester i granted this cycle.
- `req_a`  in  n*width  operand a, slot i at `[i*width +: width]`.
- `req_b`  in  n*width  operand b, same slotting.
- `rsp_valid`  out  n  one-cycle pulse: result for requester i.
- `rsp_y`  out  n*width  result, slot i; holds its last value when `rsp_valid[i]`=0.
- `lanes_busy`  out  2  number of lanes issued into stage 1 (0..3).

## Operation
- Arbiter (combinational): scan `req_valid` from index `rr` upward with wrap-around. Grant the first min(3, popcount) set bits. `req_ready = grant`.
- `req_ready[i]` depends on `req_valid[i]`. Requesters must not make `req_valid` depend on `req_ready`.
- Handshake: a transfer occurs when `req_valid[i] & req_ready[i]`. Each requester receives at most one grant per cycle.
- Lane assignment: the k-th granted requester in scan order goes to lane k.
- `rr` update:
  - Any grant: `rr` ← (index of last granted requester + 1) mod n.
  - No grant: `rr` holds.
  - When n ≤ 3, every valid requester is granted every cycle.
- Stage 1 (S1) registers per lane:
  - `vld`, requester index, a, b.
  - Ungranted lanes load `vld`=0 and a=b=0.
  - S1 drives the `dsp_add_v3` a0/b0..a2/b2 ports directly.
- Stage 2 (S2) registers per lane: `vld`, index, sum (the DSP P slice).
- Output decode: for each S2 lane with `vld`, assert `rsp_valid[idx]` and load `rsp_y` slot idx with the sum. Lane indices are always distinct, so there are no collisions.
- Arithmetic: y = (a + b) mod 2^width. Carry does not cross lanes (FOUR12). Sign extension inside the adder does not affect the low `width` bits.
- No response backpressure: throughput is 3 adds/cycle sustained, 0 bubbles.
- The DSP is used combinationally (all internal regs 0, CE=0). Its `reset` input is tied to `reset`.

## Timing
- Reset values: `rr`=0; all S1/S2 `vld`=0, indices 0, data 0; `rsp_valid`=0; `rsp_y`=0; `lanes_busy`=0.
- Latency: a pair accepted at edge k produces `rsp_valid` high during the cycle after edge k+2, i.e. a 2-cycle pipeline.
- `lanes_busy` reflects S1 contents; it is registered.
- Reset mid-operation: all in-flight operations are dropped with no response. After deassertion, arbitration restarts at `rr`=0.
- Simultaneous events: a requester may be granted while its previous result is still in the pipe. Responses return in acceptance order per requester.
- All requesters idle: S1/S2 lanes carry `vld`=0 and `rsp_valid` stays 0.

## Structure
- Package `dsp_add_v3_sched_pkg` holds:
  - `LANES`=3, `LANE_W`=12.
  - typedef `lane_t` {vld, idx[2:0], a, b}.
  - typedef `res_t` {vld, idx, y}.
- Sub-module `dsp_add_v3_rr_pick`:
  - Purely combinational.
  - Inputs: `req_valid`, `rr`.
  - Outputs: `grant[n]`, lane index for lanes 0..2, per-lane valid, next `rr`.
- The top instantiates `dsp_add_v3_rr_pick` and `dsp_add_v3`, plus the S1/S2 registers.

## Test plan
- Reset, then n=4 with only req 2 valid, a=5, b=7 → `req_ready`=4'b0100; two cycles later `rsp_valid`=4'b0100, slot 2 = 12.
- All 4 valid continuously, starting at `rr`=0 → grants cycle 1 = {0,1,2}, cycle 2 = {3,0,1}, cycle 3 = {2,3,0}. No requester is starved; `lanes_busy`=3 each cycle.
- Wrap-around: width=12, a=12'hFFF, b=12'h001 on lane 0 and a=1, b=2 on lane 1 → y=0 and y=3. No carry leaks into lane 1.
- width=8, a=8'h80, b=8'h80 → y=8'h00; a=8'h7F, b=1 → 8'h80.
- Assert reset while S1 and S2 both hold valid lanes → no `rsp_valid` pulses appear afterward; after deassertion the first grant starts from index 0.
- Back-to-back requests from requester 1 with sums 10, 20, 30 → `rsp_valid[1]` pulses on 3 consecutive cycles carrying 10, 20, 30 in order.
